// File: rtl/fetch_ifid_if.sv
// Signal bundle between the fetch/IF-ID stage and its surroundings:
// the instruction-memory handshake, the decode-side control, and the IF/ID register outputs.
interface fetch_ifid_if;
  logic        stall;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;

  modport master (
    input  stall, flush, redirect_pc, imem_rdata, imem_valid,
    output imem_req, imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted
  );

  modport slave (
    output stall, flush, redirect_pc, imem_rdata, imem_valid,
    input  imem_req, imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted
  );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch plus IF/ID register for the 16-bit CPU.
// Owns the PC, runs the imem handshake, absorbs decode stalls in a one-entry buffer, and applies redirects.
module fetch_ifid_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input logic          clk,
  input logic          rst_n,
  fetch_ifid_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_REDIRECT,
    S_HALTED
  } state_t;

  state_t      state, next_state;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic [15:0] buf_instr, buf_pc_plus2;
  logic        buf_valid;
  logic [15:0] ifid_instr, ifid_pc_plus2;
  logic        ifid_valid;

  logic take_mem, take_buf, bubble, capture, clear_buf, pc_step, pc_load;
  logic mem_is_halt, buf_is_halt;

  assign pc_plus2    = pc + 16'd2;
  assign mem_is_halt = (bus.imem_rdata[15:12] == HALT_OPCODE);
  assign buf_is_halt = buf_valid && (buf_instr[15:12] == HALT_OPCODE);

  // Gated by rst_n so the request drops the instant reset is asserted mid-transfer.
  assign bus.imem_req       = rst_n && (state == S_FETCH);
  assign bus.imem_addr      = pc;
  assign bus.halted         = (state == S_HALTED);
  assign bus.if_id_instr    = ifid_instr;
  assign bus.if_id_pc_plus2 = ifid_pc_plus2;
  assign bus.if_id_valid    = ifid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    next_state = state;
    take_mem   = 1'b0;
    take_buf   = 1'b0;
    bubble     = 1'b0;
    capture    = 1'b0;
    clear_buf  = 1'b0;
    pc_step    = 1'b0;
    pc_load    = 1'b0;
    if (bus.flush) begin
      // Redirect wins over stall and discards any same-cycle response.
      next_state = S_REDIRECT;
      pc_load    = 1'b1;
      bubble     = 1'b1;
      clear_buf  = 1'b1;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (bus.imem_valid) begin
            if (!bus.stall) begin
              take_mem = 1'b1;
              if (mem_is_halt) next_state = S_HALTED;
              else             pc_step    = 1'b1;
            end else begin
              capture    = 1'b1;
              next_state = S_HOLD;
            end
          end else if (!bus.stall) begin
            bubble = 1'b1;
          end
        end
        S_HOLD: begin
          if (!bus.stall) begin
            take_buf  = 1'b1;
            clear_buf = 1'b1;
            if (buf_is_halt) begin
              next_state = S_HALTED;
            end else begin
              pc_step    = 1'b1;
              next_state = S_FETCH;
            end
          end
        end
        S_REDIRECT: begin
          next_state = S_FETCH;
          if (!bus.stall) bubble = 1'b1;
        end
        S_HALTED: begin
          if (!bus.stall) bubble = 1'b1;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

  // NOTE: the hold buffer is a handful of flops, not a memory array, so it is reset along with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      ifid_instr    <= 16'h0000;
      ifid_pc_plus2 <= 16'h0000;
      ifid_valid    <= 1'b0;
      buf_instr     <= 16'h0000;
      buf_pc_plus2  <= 16'h0000;
      buf_valid     <= 1'b0;
    end else begin
      if (pc_load)      pc <= {bus.redirect_pc[15:1], 1'b0};
      else if (pc_step) pc <= pc_plus2;

      if (take_mem) begin
        ifid_instr    <= bus.imem_rdata;
        ifid_pc_plus2 <= pc_plus2;
        ifid_valid    <= 1'b1;
      end else if (take_buf) begin
        ifid_instr    <= buf_instr;
        ifid_pc_plus2 <= buf_pc_plus2;
        ifid_valid    <= 1'b1;
      end else if (bubble) begin
        ifid_valid <= 1'b0;
      end

      if (capture) begin
        buf_instr    <= bus.imem_rdata;
        buf_pc_plus2 <= pc_plus2;
        buf_valid    <= 1'b1;
      end else if (clear_buf) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Self-checking bench for fetch_ifid_stage: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the fetch/decode contract.
module tb_fetch_ifid_stage;

  logic clk;
  logic rst_n;
  fetch_ifid_if bus ();

  fetch_ifid_stage #(.RESET_PC(16'h0000), .HALT_OPCODE(4'hF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total  = 0;
  int n_passed = 0;

  // Reference model: what decode sees, what fetch still owes, and whether fetching is suspended.
  logic [15:0] m_pc, m_instr, m_pc2;
  logic        m_valid, m_redirect, m_halted;
  logic [31:0] m_hold_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic m_req();
    return !m_redirect && !m_halted && (m_hold_q.size() == 0);
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000;
    m_valid = 1'b0; m_redirect = 1'b0; m_halted = 1'b0;
    m_hold_q.delete();
  endtask

  task automatic deliver(input logic [15:0] instr, input logic [15:0] pc2);
    m_instr = instr; m_pc2 = pc2; m_valid = 1'b1;
    if (instr[15:12] == 4'hF) m_halted = 1'b1;
    else                      m_pc = m_pc + 16'd2;
  endtask

  task automatic model_step(input logic st, input logic fl, input logic [15:0] rp,
                            input logic vld, input logic [15:0] rd);
    logic [31:0] e;
    if (fl) begin
      m_pc = rp & 16'hFFFE; m_valid = 1'b0; m_hold_q.delete();
      m_halted = 1'b0; m_redirect = 1'b1;
    end else if (m_redirect) begin
      m_redirect = 1'b0;
      if (!st) m_valid = 1'b0;
    end else if (m_halted) begin
      if (!st) m_valid = 1'b0;
    end else if (m_hold_q.size() != 0) begin
      if (!st) begin
        e = m_hold_q.pop_front();
        deliver(e[31:16], e[15:0]);
      end
    end else if (vld) begin
      if (!st) deliver(rd, m_pc + 16'd2);
      else     m_hold_q.push_back({rd, m_pc + 16'd2});
    end else if (!st) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_regs();
    check("if_id_valid", {15'd0, bus.if_id_valid}, {15'd0, m_valid});
    check("if_id_instr", bus.if_id_instr, m_instr);
    check("if_id_pc_plus2", bus.if_id_pc_plus2, m_pc2);
    check("halted", {15'd0, bus.halted}, {15'd0, m_halted});
  endtask

  // One clock: drive inputs, check combinational outputs mid-cycle, clock, update model, check registers.
  task automatic step(input logic st, input logic fl, input logic [15:0] rp,
                      input logic vld, input logic [15:0] rd);
    bus.stall = st; bus.flush = fl; bus.redirect_pc = rp;
    bus.imem_valid = vld; bus.imem_rdata = rd;
    #1;
    check("imem_req", {15'd0, bus.imem_req}, {15'd0, m_req()});
    check("imem_addr", bus.imem_addr, m_pc);
    @(posedge clk);
    model_step(st, fl, rp, vld, rd);
    #1;
    check_regs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic st, fl, vld;
    logic [15:0] rp, rd;

    rst_n = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_pc = 16'h0000;
    bus.imem_valid = 1'b0; bus.imem_rdata = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset imem_req", {15'd0, bus.imem_req}, 16'd0);
    check("reset imem_addr", bus.imem_addr, 16'h0000);
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Single-cycle memory, back-to-back.
    step(0, 0, 16'h0, 1, 16'hA001);
    step(0, 0, 16'h0, 1, 16'hB002);
    step(0, 0, 16'h0, 1, 16'hC003);
    check("seq3 instr", bus.if_id_instr, 16'hC003);
    check("seq3 pc_plus2", bus.if_id_pc_plus2, 16'h0006);
    check("seq3 addr", bus.imem_addr, 16'h0006);

    // Three-cycle latency at pc 6.
    step(0, 0, 16'h0, 0, 16'hDEAD);
    check("lat bubble", {15'd0, bus.if_id_valid}, 16'd0);
    step(0, 0, 16'h0, 0, 16'hDEAD);
    step(0, 0, 16'h0, 1, 16'h1234);
    check("lat pc_plus2", bus.if_id_pc_plus2, 16'h0008);

    // Stall on a response cycle, held for three cycles.
    step(1, 0, 16'h0, 1, 16'h5555);
    step(1, 0, 16'h0, 1, 16'h6666);
    check("hold keeps old", bus.if_id_instr, 16'h1234);
    step(1, 0, 16'h0, 0, 16'h0000);
    step(0, 0, 16'h0, 0, 16'h0000);
    check("hold release", bus.if_id_instr, 16'h5555);
    step(0, 0, 16'h0, 1, 16'h2468);

    // Flush while stalled with a live response.
    step(1, 0, 16'h0, 1, 16'h7777);
    step(1, 1, 16'h0040, 1, 16'h8888);
    check("flush req", {15'd0, bus.imem_req}, 16'd0);
    step(0, 0, 16'h0, 1, 16'h9999);
    check("after redirect addr", bus.imem_addr, 16'h0040);
    step(0, 0, 16'h0, 1, 16'h0ABC);

    // HALT fetched at 0x0010, then resumed by a flush.
    step(0, 1, 16'h0010, 0, 16'h0);
    step(0, 0, 16'h0, 0, 16'h0);
    step(0, 0, 16'h0, 1, 16'hF000);
    check("halt pc_plus2", bus.if_id_pc_plus2, 16'h0012);
    check("halt pc", bus.imem_addr, 16'h0010);
    step(0, 0, 16'h0, 1, 16'h1111);
    step(0, 1, 16'h0020, 0, 16'h0);
    step(0, 0, 16'h0, 0, 16'h0);
    step(0, 0, 16'h0, 1, 16'h1357);

    // Wrap at the top of the address space; odd redirect bit dropped.
    step(0, 1, 16'hFFFF, 0, 16'h0);
    step(0, 0, 16'h0, 0, 16'h0);
    step(0, 0, 16'h0, 1, 16'h1111);
    check("wrap pc_plus2 0", bus.if_id_pc_plus2, 16'h0000);
    step(0, 0, 16'h0, 1, 16'h2222);
    check("wrap pc_plus2 2", bus.if_id_pc_plus2, 16'h0002);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      st  = ($urandom_range(3) == 0);
      fl  = ($urandom_range(19) == 0);
      vld = ($urandom_range(9) < 6);
      rp  = 16'($urandom);
      rd  = {(($urandom_range(9) == 0) ? 4'hF : 4'($urandom_range(14))), 12'($urandom)};
      step(st, fl, rp, vld, rd);
    end

    // Reset asserted mid-request clears everything at once.
    step(0, 1, 16'h0100, 0, 16'h0);
    step(0, 0, 16'h0, 0, 16'h0);
    bus.imem_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset imem_req", {15'd0, bus.imem_req}, 16'd0);
    check("midreset imem_addr", bus.imem_addr, 16'h0000);
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    step(0, 0, 16'h0, 1, 16'h4321);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
